// File: rtl/pipe_rx_ts_detect.sv
// pipe_rx_ts_detect -- PIPE 16-bit receive-side TS1/TS2 ordered-set parser.
// Collects a 16-symbol training set (8 words W0..W7), extracts link/lane/
// N_FTS/rate/training-control fields, and counts consecutive identical sets
// for the LTSSM.
// Optional build macro: TS_POLARITY_DETECT_EN adds rx_pol_inv and accepts
// polarity-inverted TS identifiers.
module pipe_rx_ts_detect #(
  parameter int CONSEC_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk_125mhz,
  input  logic             reset_n,
  input  logic [15:0]      rxdata16,
  input  logic [1:0]       rxdatak16,
  input  logic             rxvalid16,
  input  logic             rxidle16,
  input  logic [2:0]       rxstatus,
  input  logic             clear_cnt,
  output logic             ts_valid,
  output logic             ts_is_ts2,
  output logic             ts_link_pad,
  output logic [7:0]       ts_link_num,
  output logic             ts_lane_pad,
  output logic [7:0]       ts_lane_num,
  output logic [7:0]       ts_nfts,
  output logic [7:0]       ts_rate,
  output logic [7:0]       ts_tctl,
  output logic [CNT_W-1:0] ts_consec,
  output logic             ts_consec_hit,
`ifdef TS_POLARITY_DETECT_EN
  output logic             rx_pol_inv,
`endif
  output logic             ts_err
);

  localparam logic [7:0] K_COM      = 8'hBC;
  localparam logic [7:0] K_PAD      = 8'hF7;
  localparam logic [7:0] ID_TS1     = 8'h4A;
  localparam logic [7:0] ID_TS2     = 8'h45;
  localparam logic [7:0] ID_TS1_INV = 8'hB5;
  localparam logic [7:0] ID_TS2_INV = 8'hBA;
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(CONSEC_MAX);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_wcnt;

  // Fields of the set currently being collected
  logic [7:0]       r_link;
  logic             r_link_pad;
  logic [7:0]       r_lane;
  logic             r_lane_pad;
  logic [7:0]       r_nfts;
  logic [7:0]       r_rate;
  logic [7:0]       r_tctl;
  logic [7:0]       r_id;

  // Registered outputs; they also serve as the previous-TS reference
  logic             r_ts_valid;
  logic             r_ts_is_ts2;
  logic             r_ts_link_pad;
  logic [7:0]       r_ts_link_num;
  logic             r_ts_lane_pad;
  logic [7:0]       r_ts_lane_num;
  logic [7:0]       r_ts_nfts;
  logic [7:0]       r_ts_rate;
  logic [7:0]       r_ts_tctl;
  logic [CNT_W-1:0] r_ts_consec;
  logic             r_ts_consec_hit;
  logic             r_ts_err;
  logic             r_ref_vld;

  logic [7:0]       w_lo;
  logic [7:0]       w_hi;
  logic             w_clean;
  logic             w_lo_com;
  logic             w_lo_pad;
  logic             w_hi_pad;
  logic             w_start;
  logic             w_both_data;
  logic             w_id_legal;
  logic             w_word_ok;
  logic             w_accept;
  logic             w_abort;
  logic             w_col_ts2;
  logic             w_fields_match;
  logic [CNT_W-1:0] w_consec_inc;
  logic [CNT_W-1:0] w_consec_nxt;

  assign w_lo        = rxdata16[7:0];
  assign w_hi        = rxdata16[15:8];
  // Status codes 100..111 are all receive errors
  assign w_clean     = rxvalid16 && !rxidle16 && (rxstatus < 3'b100);
  assign w_lo_com    = rxdatak16[0] && (w_lo == K_COM);
  assign w_lo_pad    = rxdatak16[0] && (w_lo == K_PAD);
  assign w_hi_pad    = rxdatak16[1] && (w_hi == K_PAD);
  assign w_both_data = (rxdatak16 == 2'b00);
  // A W0 needs COM low and a data or PAD link byte; COM+SKP/FTS is not a TS
  assign w_start     = w_clean && w_lo_com && (!rxdatak16[1] || w_hi_pad);

`ifdef TS_POLARITY_DETECT_EN
  logic w_col_inv;
  logic r_pol_inv;
  assign w_id_legal = (w_lo == ID_TS1) || (w_lo == ID_TS2) ||
                      (w_lo == ID_TS1_INV) || (w_lo == ID_TS2_INV);
  assign w_col_inv  = (r_id == ID_TS1_INV) || (r_id == ID_TS2_INV);
  assign rx_pol_inv = r_pol_inv;
`else
  assign w_id_legal = (w_lo == ID_TS1) || (w_lo == ID_TS2);
`endif

  assign w_col_ts2 = (r_id == ID_TS2) || (r_id == ID_TS2_INV);

  // Legality of the current word for the slot the collector expects next
  always_comb begin
    w_word_ok = 1'b0;
    case (r_wcnt)
      3'd1:    w_word_ok = w_clean && (!rxdatak16[0] || w_lo_pad) && !rxdatak16[1];
      3'd2:    w_word_ok = w_clean && w_both_data;
      3'd3:    w_word_ok = w_clean && w_both_data && w_id_legal && (w_hi == w_lo);
      3'd4, 3'd5, 3'd6, 3'd7:
               w_word_ok = w_clean && w_both_data && (w_lo == r_id) && (w_hi == r_id);
      default: w_word_ok = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_COLLECT) && w_word_ok && (r_wcnt == 3'd7);
  assign w_abort  = (r_state == S_COLLECT) && !w_word_ok;

  // The outputs hold the last accepted set, so they double as the reference
  assign w_fields_match = r_ref_vld &&
                          (r_ts_is_ts2   == w_col_ts2)  &&
                          (r_ts_link_pad == r_link_pad) && (r_ts_link_num == r_link) &&
                          (r_ts_lane_pad == r_lane_pad) && (r_ts_lane_num == r_lane) &&
                          (r_ts_nfts     == r_nfts)     && (r_ts_rate     == r_rate) &&
                          (r_ts_tctl     == r_tctl);
  assign w_consec_inc   = (r_ts_consec >= C_MAX) ? C_MAX : (r_ts_consec + CNT_W'(1));
  assign w_consec_nxt   = w_fields_match ? w_consec_inc : CNT_W'(1);

  // Field capture for the set in flight; a fresh W0 always reloads the link
  always_ff @(posedge clk_125mhz) begin
    if (w_start) begin
      r_link     <= w_hi;
      r_link_pad <= rxdatak16[1];
    end
    if (r_state == S_COLLECT) begin
      case (r_wcnt)
        3'd1: begin
          r_lane     <= w_lo;
          r_lane_pad <= rxdatak16[0];
          r_nfts     <= w_hi;
        end
        3'd2: begin
          r_rate <= w_lo;
          r_tctl <= w_hi;
        end
        3'd3:    r_id <= w_lo;
        default: ;
      endcase
    end
  end

  // Parser FSM with registered result, error and consecutive-count outputs
  always_ff @(posedge clk_125mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_wcnt          <= 3'd0;
      r_ts_valid      <= 1'b0;
      r_ts_err        <= 1'b0;
      r_ts_is_ts2     <= 1'b0;
      r_ts_link_pad   <= 1'b0;
      r_ts_link_num   <= 8'h00;
      r_ts_lane_pad   <= 1'b0;
      r_ts_lane_num   <= 8'h00;
      r_ts_nfts       <= 8'h00;
      r_ts_rate       <= 8'h00;
      r_ts_tctl       <= 8'h00;
      r_ts_consec     <= '0;
      r_ts_consec_hit <= 1'b0;
      r_ref_vld       <= 1'b0;
`ifdef TS_POLARITY_DETECT_EN
      r_pol_inv       <= 1'b0;
`endif
    end else begin
      r_ts_valid <= 1'b0;
      r_ts_err   <= 1'b0;
      case (r_state)
        // DONE lasts one cycle and examines its word exactly like IDLE
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state <= S_COLLECT;
            r_wcnt  <= 3'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_COLLECT: begin
          if (w_word_ok) begin
            if (r_wcnt == 3'd7) begin
              r_state       <= S_DONE;
              r_ts_valid    <= 1'b1;
              r_ts_is_ts2   <= w_col_ts2;
              r_ts_link_pad <= r_link_pad;
              r_ts_link_num <= r_link;
              r_ts_lane_pad <= r_lane_pad;
              r_ts_lane_num <= r_lane;
              r_ts_nfts     <= r_nfts;
              r_ts_rate     <= r_rate;
              r_ts_tctl     <= r_tctl;
            end else begin
              r_wcnt <= r_wcnt + 3'd1;
            end
          end else begin
            r_ts_err <= 1'b1;
            if (w_start) begin
              r_state <= S_COLLECT;
              r_wcnt  <= 3'd1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Clear outranks both the accept update and the abort zeroing
      if (clear_cnt) begin
        r_ts_consec     <= '0;
        r_ts_consec_hit <= 1'b0;
        r_ref_vld       <= 1'b0;
      end else if (w_accept) begin
        r_ts_consec     <= w_consec_nxt;
        r_ts_consec_hit <= (w_consec_nxt >= C_MAX);
        r_ref_vld       <= 1'b1;
      end else if (w_abort) begin
        r_ts_consec     <= '0;
        r_ts_consec_hit <= 1'b0;
      end

`ifdef TS_POLARITY_DETECT_EN
      if (w_accept && w_col_inv) begin
        r_pol_inv <= 1'b1;
      end
`endif
    end
  end

  assign ts_valid      = r_ts_valid;
  assign ts_err        = r_ts_err;
  assign ts_is_ts2     = r_ts_is_ts2;
  assign ts_link_pad   = r_ts_link_pad;
  assign ts_link_num   = r_ts_link_num;
  assign ts_lane_pad   = r_ts_lane_pad;
  assign ts_lane_num   = r_ts_lane_num;
  assign ts_nfts       = r_ts_nfts;
  assign ts_rate       = r_ts_rate;
  assign ts_tctl       = r_ts_tctl;
  assign ts_consec     = r_ts_consec;
  assign ts_consec_hit = r_ts_consec_hit;

endmodule

// File: tb/tb_pipe_rx_ts_detect.sv
// Self-checking bench for pipe_rx_ts_detect: directed steps followed by a
// randomized stream of training sets, fillers, aborts and clears, checked
// against a set-level reference model.
module tb_pipe_rx_ts_detect;
  localparam int CONSEC_MAX = 8;
  localparam int CNT_W      = 4;

  logic             clk_125mhz = 1'b0;
  logic             reset_n;
  logic [15:0]      rxdata16;
  logic [1:0]       rxdatak16;
  logic             rxvalid16;
  logic             rxidle16;
  logic [2:0]       rxstatus;
  logic             clear_cnt;
  logic             ts_valid;
  logic             ts_is_ts2;
  logic             ts_link_pad;
  logic [7:0]       ts_link_num;
  logic             ts_lane_pad;
  logic [7:0]       ts_lane_num;
  logic [7:0]       ts_nfts;
  logic [7:0]       ts_rate;
  logic [7:0]       ts_tctl;
  logic [CNT_W-1:0] ts_consec;
  logic             ts_consec_hit;
  logic             ts_err;
`ifdef TS_POLARITY_DETECT_EN
  logic             rx_pol_inv;
`endif

  always #4 clk_125mhz = ~clk_125mhz;

  pipe_rx_ts_detect #(.CONSEC_MAX(CONSEC_MAX), .CNT_W(CNT_W)) dut (
    .clk_125mhz   (clk_125mhz),
    .reset_n      (reset_n),
    .rxdata16     (rxdata16),
    .rxdatak16    (rxdatak16),
    .rxvalid16    (rxvalid16),
    .rxidle16     (rxidle16),
    .rxstatus     (rxstatus),
    .clear_cnt    (clear_cnt),
    .ts_valid     (ts_valid),
    .ts_is_ts2    (ts_is_ts2),
    .ts_link_pad  (ts_link_pad),
    .ts_link_num  (ts_link_num),
    .ts_lane_pad  (ts_lane_pad),
    .ts_lane_num  (ts_lane_num),
    .ts_nfts      (ts_nfts),
    .ts_rate      (ts_rate),
    .ts_tctl      (ts_tctl),
    .ts_consec    (ts_consec),
    .ts_consec_hit(ts_consec_hit),
`ifdef TS_POLARITY_DETECT_EN
    .rx_pol_inv   (rx_pol_inv),
`endif
    .ts_err       (ts_err)
  );

  typedef struct packed {
    logic       ts2;
    logic       inv;
    logic       link_pad;
    logic [7:0] link;
    logic       lane_pad;
    logic [7:0] lane;
    logic [7:0] nfts;
    logic [7:0] rate;
    logic [7:0] tctl;
  } ts_t;

  int   checks = 0;
  int   errors = 0;

  // Reference model state: last accepted set, counter, reference validity
  ts_t  m_last;
  bit   m_ref_vld;
  int   m_cnt;
  bit   m_pol;

  logic [15:0] wd [8];
  logic [1:0]  wk [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ts_t mk(input bit ts2, input bit inv, input bit lkp, input logic [7:0] lk,
                             input bit lnp, input logic [7:0] ln, input logic [7:0] nfts,
                             input logic [7:0] rate, input logic [7:0] tctl);
    ts_t t;
    t.ts2 = ts2; t.inv = inv;
    t.link_pad = lkp; t.link = lkp ? 8'hF7 : lk;
    t.lane_pad = lnp; t.lane = lnp ? 8'hF7 : ln;
    t.nfts = nfts; t.rate = rate; t.tctl = tctl;
    return t;
  endfunction

  function automatic ts_t rand_ts();
    bit inv;
`ifdef TS_POLARITY_DETECT_EN
    inv = ($urandom_range(0, 9) == 0);
`else
    inv = 1'b0;
`endif
    return mk(1'($urandom_range(0, 1)), inv, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 3) * 16),
              8'($urandom_range(1, 2)), 8'($urandom_range(0, 1)));
  endfunction

  // Symbol stream of one set: COM|link, lane|nfts, rate|tctl, ten ID symbols
  function automatic void build(input ts_t t);
    logic [7:0] id;
    id = t.ts2 ? 8'h45 : 8'h4A;
    if (t.inv) id = ~id;
    wd[0] = {t.link, 8'hBC};   wk[0] = {t.link_pad, 1'b1};
    wd[1] = {t.nfts, t.lane};  wk[1] = {1'b0, t.lane_pad};
    wd[2] = {t.tctl, t.rate};  wk[2] = 2'b00;
    for (int i = 3; i < 8; i++) begin
      wd[i] = {id, id};
      wk[i] = 2'b00;
    end
  endfunction

  function automatic bit same_set(input ts_t a, input ts_t b);
    return (a.ts2 == b.ts2) && (a.link_pad == b.link_pad) && (a.link == b.link) &&
           (a.lane_pad == b.lane_pad) && (a.lane == b.lane) && (a.nfts == b.nfts) &&
           (a.rate == b.rate) && (a.tctl == b.tctl);
  endfunction

  task automatic model_reset();
    m_last = '0; m_ref_vld = 0; m_cnt = 0; m_pol = 0;
  endtask

  task automatic model_accept(input ts_t t, input bit clr);
    if (clr) begin
      m_cnt = 0;
      m_ref_vld = 0;
    end else begin
      if (m_ref_vld && same_set(t, m_last)) m_cnt = (m_cnt + 1 > CONSEC_MAX) ? CONSEC_MAX : m_cnt + 1;
      else m_cnt = 1;
      m_ref_vld = 1;
    end
    m_last = t;
    if (t.inv) m_pol = 1;
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_ts2"},      ts_is_ts2,     m_last.ts2);
    check({tag, "_linkpad"},  ts_link_pad,   m_last.link_pad);
    check({tag, "_link"},     ts_link_num,   m_last.link);
    check({tag, "_lanepad"},  ts_lane_pad,   m_last.lane_pad);
    check({tag, "_lane"},     ts_lane_num,   m_last.lane);
    check({tag, "_nfts"},     ts_nfts,       m_last.nfts);
    check({tag, "_rate"},     ts_rate,       m_last.rate);
    check({tag, "_tctl"},     ts_tctl,       m_last.tctl);
    check({tag, "_consec"},   ts_consec,     m_cnt);
    check({tag, "_hit"},      ts_consec_hit, (m_cnt >= CONSEC_MAX));
`ifdef TS_POLARITY_DETECT_EN
    check({tag, "_polinv"},   rx_pol_inv,    m_pol);
`endif
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic v,
                       input logic idl, input logic [2:0] st, input logic clr);
    rxdata16 = d; rxdatak16 = k; rxvalid16 = v; rxidle16 = idl; rxstatus = st; clear_cnt = clr;
    @(posedge clk_125mhz);
    #1;
  endtask

  // bad_kind: 0 rxvalid low, 1 rxidle, 2 random error status, 3 illegal K / ID
  // mismatch, 4 status 100, 9 word left as built (set is inherently illegal)
  task automatic send_ts(input string tag, input ts_t t, input int bad_w, input int bad_kind,
                         input bit clr_last, input bit restart);
    logic [15:0] d;
    logic [1:0]  k;
    logic        v, idl, clr;
    logic [2:0]  st;
    build(t);
    for (int i = 0; i < 8; i++) begin
      d = wd[i]; k = wk[i]; v = 1'b1; idl = 1'b0; st = 3'b000;
      if (i == bad_w) begin
        case (bad_kind)
          0: v = 1'b0;
          1: idl = 1'b1;
          2: st = 3'($urandom_range(4, 7));
          3: if (i < 3) k[1] = 1'b1; else d[15:8] = d[15:8] ^ 8'h0F;
          4: st = 3'b100;
          default: ;
        endcase
      end
      clr = clr_last && (bad_w < 0) && (i == 7);
      drive(d, k, v, idl, st, clr);
      if (i == bad_w) begin
        m_cnt = 0;
        check({tag, "_err"},   ts_err,   1'b1);
        check({tag, "_vld"},   ts_valid, 1'b0);
        check_fields({tag, "_abort"});
        break;
      end else if (i == 7) begin
        model_accept(t, clr);
        check({tag, "_vld"}, ts_valid, 1'b1);
        check({tag, "_err"}, ts_err,   1'b0);
        check_fields(tag);
      end else begin
        if (restart && i == 0) m_cnt = 0;
        check({tag, "_midvld"}, ts_valid, 1'b0);
        check({tag, "_miderr"}, ts_err,   (restart && i == 0));
        if (restart && i == 0) check({tag, "_rstcnt"}, ts_consec, 0);
      end
    end
    clear_cnt = 1'b0;
  endtask

  task automatic send_partial(input ts_t t, input int n);
    build(t);
    for (int i = 0; i < n; i++) begin
      drive(wd[i], wk[i], 1'b1, 1'b0, 3'b000, 1'b0);
      check("partial_vld", ts_valid, 1'b0);
      check("partial_err", ts_err,   1'b0);
    end
  endtask

  // Words that must never start or disturb a set
  task automatic send_fill(input int kind, input bit clr);
    case (kind)
      0: drive({8'h1C, 8'hBC}, 2'b11, 1'b1, 1'b0, 3'b000, clr);
      1: drive({8'h3C, 8'hBC}, 2'b11, 1'b1, 1'b0, 3'b000, clr);
      2: drive({8'hBC, 8'($urandom_range(0, 255))}, 2'b10, 1'b1, 1'b0, 3'b000, clr);
      3: drive({8'($urandom_range(0, 255)), 8'h00}, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 3'b000, clr);
      4: drive(16'($urandom), 2'b00, 1'b1, 1'b0, 3'b000, clr);
      default: drive({8'h1C, 8'h1C}, 2'b11, 1'b1, 1'b0, 3'b000, clr);
    endcase
    clear_cnt = 1'b0;
    if (clr) begin
      m_cnt = 0;
      m_ref_vld = 0;
    end
    check("fill_vld", ts_valid, 1'b0);
    check("fill_err", ts_err,   1'b0);
    check_fields("fill");
  endtask

  initial begin
    ts_t t1p, t2, cur;
    int  bw, bk;
    bit  rs;

    reset_n = 1'b0;
    rxdata16 = 16'h0000; rxdatak16 = 2'b00; rxvalid16 = 1'b0; rxidle16 = 1'b1;
    rxstatus = 3'b000; clear_cnt = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_125mhz);
    #1;
    check("rst_vld", ts_valid, 1'b0);
    check("rst_err", ts_err,   1'b0);
    check_fields("rst");
    reset_n = 1'b1;
    @(posedge clk_125mhz);
    #1;

    // Eight back-to-back TS1 with PAD link and lane
    t1p = mk(0, 0, 1, 8'h00, 1, 8'h00, 8'h10, 8'h02, 8'h00);
    for (int n = 0; n < 8; n++) send_ts("t1", t1p, -1, 0, 0, 0);
    check("t1_consec8", ts_consec, 8);
    check("t1_hit8",    ts_consec_hit, 1'b1);

    // Four TS2 then one with a different N_FTS
    t2 = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h10, 8'h02, 8'h00);
    for (int n = 0; n < 4; n++) send_ts("t2", t2, -1, 0, 0, 0);
    check("t2_consec4", ts_consec, 4);
    t2.nfts = 8'h20;
    send_ts("t2b", t2, -1, 0, 0, 0);
    check("t2_consec1", ts_consec, 1);
    check("t2_nfts",    ts_nfts,   8'h20);

    // ID mismatch in W5 upper byte, then error status during W4
    send_ts("t3", t1p, 5, 3, 0, 0);
    check("t3_consec0", ts_consec, 0);
    send_ts("t4", t1p, 4, 4, 0, 0);
    send_ts("t4b", t1p, -1, 0, 0, 0);
    check("t4_consec1", ts_consec, 1);

    // COM+SKP+SKP+SKP between sets, then clear coinciding with the accept
    send_ts("t5a", t1p, -1, 0, 0, 0);
    send_fill(0, 0);
    send_fill(5, 0);
    send_ts("t5b", t1p, -1, 0, 1, 0);
    check("t5_consec0", ts_consec, 0);

    // Inverted TS1 identifiers
`ifdef TS_POLARITY_DETECT_EN
    send_ts("t6", mk(0, 1, 1, 8'h00, 1, 8'h00, 8'h10, 8'h02, 8'h00), -1, 0, 0, 0);
    check("t6_pol", rx_pol_inv, 1'b1);
    send_ts("t6b", t1p, -1, 0, 0, 0);
    send_ts("t6c", t2, -1, 0, 0, 0);
    check("t6_pol_sticky", rx_pol_inv, 1'b1);
`else
    send_ts("t6", mk(0, 1, 1, 8'h00, 1, 8'h00, 8'h10, 8'h02, 8'h00), 3, 9, 0, 0);
`endif

    // A legal W0 in the middle of a set aborts and restarts collection
    send_partial(t2, 4);
    send_ts("restart", t2, -1, 0, 0, 1);

    // Reset in the middle of a set discards it without an error pulse
    send_partial(t1p, 5);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst_vld", ts_valid, 1'b0);
    check("midrst_err", ts_err,   1'b0);
    check_fields("midrst");
    @(posedge clk_125mhz);
    #1 reset_n = 1'b1;
    send_ts("postrst", t1p, -1, 0, 0, 0);

    // Randomized stream
    cur = t1p;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 99) >= 60) cur = rand_ts();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        send_fill(int'($urandom_range(0, 5)), ($urandom_range(0, 19) == 0));
      rs = ($urandom_range(0, 19) == 0);
      if (rs) send_partial(cur, int'($urandom_range(1, 7)));
      if ($urandom_range(0, 99) < 15) begin
        bw = int'($urandom_range(1, 7));
        bk = int'($urandom_range(0, 3));
      end else begin
        bw = -1;
        bk = 0;
      end
      if (cur.inv) begin
`ifndef TS_POLARITY_DETECT_EN
        bw = 3;
        bk = 9;
`endif
      end
      send_ts("rnd", cur, bw, bk, ($urandom_range(0, 9) == 0), rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
